cache_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single direct-mapped cache subsystem (cache controller, tag/valid/data RAMs, main memory) between two requesters, e.g. instruction fetch (port 0) and load/store (port 1). It sits between the requesters and the cache's command interface. It latches one request at a time, holds the cache command until the cache reports completion, and returns read data with a one-cycle acknowledge. A watchdog aborts any cache operation that exceeds a fixed cycle budget and flags an error.

---
 rtl/cache_arbiter.sv | 114 +++++++++++
 tb/tb_cache_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-port round-robin front end for the shared direct-mapped cache.
// One request is latched and held on the cache command lines until c_done arrives or the watchdog fires.
module cache_arbiter #(
  parameter int memory_bits = 5,
  parameter int memory_size = 32,
  parameter int TIMEOUT     = 15,
  parameter int TO_BITS     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [memory_bits-1:0] addr0,
  input  logic [memory_bits-1:0] addr1,
  input  logic [memory_size-1:0] wdata0,
  input  logic [memory_size-1:0] wdata1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   err,
  output logic [memory_size-1:0] rdata,
  output logic                   busy,
  output logic [memory_bits-1:0] c_addr,
  output logic                   c_read,
  output logic                   c_write,
  output logic [memory_size-1:0] c_wdata,
  input  logic [memory_size-1:0] c_rdata,
  input  logic                   c_done
);
  typedef struct packed {
    logic                   we;
    logic [memory_bits-1:0] addr;
    logic [memory_size-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state;
  req_t [1:0]         rq;
  logic [1:0]         req;
  logic [1:0]         ack;
  logic               gnt;
  logic               last_grant;
  logic               pick;
  logic [TO_BITS-1:0] wd;

  assign req   = {req1, req0};
  assign rq[0] = {we0, addr0, wdata0};
  assign rq[1] = {we1, addr1, wdata1};
  // On a tie the port that did not win last time goes next.
  assign pick  = (req[0] & req[1]) ? ~last_grant : req[1];
  assign ack0  = ack[0];
  assign ack1  = ack[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      wd         <= '0;
      ack        <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      c_read     <= 1'b0;
      c_write    <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt        <= pick;
            last_grant <= pick;
            c_addr     <= rq[pick].addr;
            c_wdata    <= rq[pick].wdata;
            c_write    <= rq[pick].we;
            c_read     <= ~rq[pick].we;
            wd         <= '0;
            busy       <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // c_done takes priority over a watchdog expiry in the same cycle.
          if (c_done) begin
            rdata    <= c_write ? '0 : c_rdata;
            err      <= 1'b0;
            c_read   <= 1'b0;
            c_write  <= 1'b0;
            ack[gnt] <= 1'b1;
            state    <= RESP;
          end else if (wd == TO_BITS'(TIMEOUT - 1)) begin
            rdata    <= '0;
            err      <= 1'b1;
            c_read   <= 1'b0;
            c_write  <= 1'b0;
            ack[gnt] <= 1'b1;
            state    <= RESP;
          end else begin
            wd <= wd + TO_BITS'(1);
          end
        end
        RESP: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized and directed bench for cache_arbiter; the cache is emulated by pulsing c_done after a chosen delay.
module tb_cache_arbiter;
  localparam int MB = 5;
  localparam int MS = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [MB-1:0] addr0, addr1;
  logic [MS-1:0] wdata0, wdata1;
  logic          ack0, ack1, err, busy, c_read, c_write, c_done;
  logic [MS-1:0] rdata, c_wdata, c_rdata;
  logic [MB-1:0] c_addr;

  int checks = 0;
  int errors = 0;
  logic mlast;

  logic [MB-1:0] obs_addr;
  logic [MS-1:0] obs_wdata, obs_rdata;
  logic [1:0]    obs_cmd, obs_ack;
  logic [2:0]    obs_post;
  logic          obs_err, obs_tmo, obs_stable;
  int            obs_cyc;

  cache_arbiter #(.memory_bits(MB), .memory_size(MS), .TIMEOUT(TO), .TO_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
    .c_addr(c_addr), .c_read(c_read), .c_write(c_write), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done)
  );

  always #5 clk = ~clk;

  // Port the arbitration rule selects for the current request pattern.
  function automatic logic exp_port(input logic r0, input logic r1);
    return (r0 && r1) ? !mlast : r1;
  endfunction

  // Waits for a command to appear, answers it with c_done after k BUSY cycles (0 = never),
  // records what the DUT showed, then drops the requests in drop and observes the IDLE cycle.
  task automatic run_op(input int k, input logic [MS-1:0] rd, input logic [1:0] drop, input bit scr);
    bit started = 0;
    obs_tmo = 0;
    obs_stable = 1;
    obs_cyc = 0;
    obs_ack = '0;
    obs_post = '0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (c_read | c_write) begin started = 1; break; end
    end
    if (!started) begin obs_tmo = 1; return; end
    obs_addr = c_addr; obs_wdata = c_wdata; obs_cmd = {c_read, c_write}; obs_cyc = 1;
    if (scr) begin
      addr0 = MB'($urandom); addr1 = MB'($urandom); wdata0 = $urandom; wdata1 = $urandom;
      we0 = 1'($urandom); we1 = 1'($urandom);
    end
    for (int i = 1; i <= 40; i++) begin
      c_done = (i == k);
      c_rdata = rd;
      @(negedge clk);
      c_done = 1'b0;
      c_rdata = $urandom;
      if (!(c_read | c_write)) break;
      if ({c_read, c_write} != obs_cmd || c_addr != obs_addr || c_wdata != obs_wdata ||
          ack0 || ack1 || !busy) obs_stable = 0;
      obs_cyc++;
      if (i == 40) obs_tmo = 1;
    end
    obs_ack = {ack1, ack0}; obs_rdata = rdata; obs_err = err;
    if (drop[0]) req0 = 1'b0;
    if (drop[1]) req1 = 1'b0;
    @(negedge clk);
    obs_post = {ack1, ack0, busy};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mlast = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ack0, ack1, err, busy, c_read, c_write} !== 6'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 000000", {ack0, ack1, err, busy, c_read, c_write});
    end
    checks++;
    if ({rdata, c_addr, c_wdata} !== '0) begin
      errors++; $display("FAIL reset_data got rdata=%h c_addr=%h c_wdata=%h want 0", rdata, c_addr, c_wdata);
    end
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 5'h0B;
    run_op(3, 32'hDEADBEEF, 2'b01, 0);
    mlast = 0;
    checks++;
    if (obs_tmo !== 0) begin errors++; $display("FAIL read_bound got timeout want none"); end
    checks++;
    if ({obs_cmd, obs_addr} !== {2'b10, 5'h0B}) begin
      errors++; $display("FAIL read_cmd got cmd=%b addr=%h want 10 0b", obs_cmd, obs_addr);
    end
    checks++;
    if (obs_cyc !== 3 || !obs_stable) begin
      errors++; $display("FAIL read_len got %0d stable=%0d want 3 1", obs_cyc, obs_stable);
    end
    checks++;
    if ({obs_ack, obs_err, obs_rdata} !== {2'b01, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL read_resp got ack=%b err=%b rdata=%h want 01 0 deadbeef", obs_ack, obs_err, obs_rdata);
    end
    checks++;
    if (obs_post !== 3'b000) begin errors++; $display("FAIL read_post got %b want 000", obs_post); end
  endtask

  task automatic test_write();
    req1 = 1; we1 = 1; addr1 = 5'h1F; wdata1 = 32'h12345678;
    run_op(1, 32'hFFFF0000, 2'b10, 0);
    mlast = 1;
    checks++;
    if ({obs_cmd, obs_addr, obs_wdata} !== {2'b01, 5'h1F, 32'h12345678}) begin
      errors++; $display("FAIL write_cmd got cmd=%b addr=%h wdata=%h want 01 1f 12345678", obs_cmd, obs_addr, obs_wdata);
    end
    checks++;
    if ({obs_ack, obs_err, obs_rdata} !== {2'b10, 1'b0, 32'h0} || obs_cyc !== 1) begin
      errors++; $display("FAIL write_resp got ack=%b err=%b rdata=%h len=%0d want 10 0 0 1", obs_ack, obs_err, obs_rdata, obs_cyc);
    end
  endtask

  task automatic test_contention();
    logic p;
    do_reset();
    addr0 = 5'h03; addr1 = 5'h1C; we0 = 0; we1 = 0; req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      p = exp_port(1, 1);
      run_op(2, 32'hA000_0000 + i, 2'b00, 0);
      mlast = p;
      checks++;
      if (obs_addr !== (p ? 5'h1C : 5'h03) || obs_ack !== (p ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contend_%0d got addr=%h ack=%b want port %0d", i, obs_addr, obs_ack, p);
      end
      checks++;
      if (obs_rdata !== 32'hA000_0000 + i || obs_cyc !== 2 || !obs_stable) begin
        errors++; $display("FAIL contend_data_%0d got rdata=%h len=%0d want %h 2", i, obs_rdata, obs_cyc, 32'hA000_0000 + i);
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_watchdog();
    req0 = 1; we0 = 0; addr0 = 5'h0A;
    run_op(0, 32'h5555AAAA, 2'b01, 0);
    mlast = 0;
    checks++;
    if (obs_cyc !== TO || obs_cmd !== 2'b10) begin
      errors++; $display("FAIL wdog_len got %0d cmd=%b want %0d 10", obs_cyc, obs_cmd, TO);
    end
    checks++;
    if ({obs_ack, obs_err, obs_rdata} !== {2'b01, 1'b1, 32'h0}) begin
      errors++; $display("FAIL wdog_resp got ack=%b err=%b rdata=%h want 01 1 0", obs_ack, obs_err, obs_rdata);
    end
    c_done = 1; c_rdata = 32'h77777777;
    @(negedge clk);
    c_done = 0;
    checks++;
    if ({ack0, ack1, busy, c_read, c_write} !== 5'b0) begin
      errors++; $display("FAIL late_done got %b want 00000", {ack0, ack1, busy, c_read, c_write});
    end
    @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, err, rdata} !== {4'b0001, 32'h0}) begin
      errors++; $display("FAIL late_done_hold got ack=%b%b busy=%b err=%b rdata=%h want 00 0 1 0", ack0, ack1, busy, err, rdata);
    end
  endtask

  task automatic test_collision();
    req0 = 1; we0 = 0; addr0 = 5'h11;
    run_op(TO, 32'hCAFEF00D, 2'b01, 0);
    mlast = 0;
    checks++;
    if ({obs_ack, obs_err, obs_rdata} !== {2'b01, 1'b0, 32'hCAFEF00D} || obs_cyc !== TO) begin
      errors++; $display("FAIL collide got ack=%b err=%b rdata=%h len=%0d want 01 0 cafef00d %0d", obs_ack, obs_err, obs_rdata, obs_cyc, TO);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    req1 = 1; we1 = 1; addr1 = 5'h07; wdata1 = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (c_write !== 1'b1) begin errors++; $display("FAIL midop_busy got c_write=%b want 1", c_write); end
    reset = 0;
    #1;
    checks++;
    if ({c_read, c_write, busy, ack0, ack1, err} !== 6'b0 || rdata !== '0) begin
      errors++; $display("FAIL midop_reset got %b rdata=%h want 000000 0", {c_read, c_write, busy, ack0, ack1, err}, rdata);
    end
    req1 = 0;
    @(negedge clk);
    reset = 1; mlast = 1;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 5'h02; addr1 = 5'h19;
    run_op(1, 32'h01020304, 2'b11, 0);
    mlast = 0;
    checks++;
    if (obs_ack !== 2'b01 || obs_addr !== 5'h02 || obs_rdata !== 32'h01020304) begin
      errors++; $display("FAIL midop_tie got ack=%b addr=%h rdata=%h want 01 02 01020304", obs_ack, obs_addr, obs_rdata);
    end
  endtask

  task automatic test_random();
    logic r0, r1, p, pwe, terr;
    logic [MB-1:0] paddr;
    logic [MS-1:0] pwd, rd, erd;
    int k, ecyc;
    for (int n = 0; n < 24; n++) begin
      {r1, r0} = 2'($urandom_range(1, 3));
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = MB'($urandom); addr1 = MB'($urandom);
      wdata0 = $urandom; wdata1 = $urandom;
      rd = $urandom;
      case ($urandom_range(0, 4))
        0:       k = 0;
        1:       k = $urandom_range(13, 17);
        default: k = $urandom_range(1, 6);
      endcase
      p = exp_port(r0, r1);
      pwe = p ? we1 : we0; paddr = p ? addr1 : addr0; pwd = p ? wdata1 : wdata0;
      terr = (k == 0 || k > TO);
      ecyc = terr ? TO : k;
      erd = (terr || pwe) ? '0 : rd;
      req0 = r0; req1 = r1;
      run_op(k, rd, 2'b11, 1);
      mlast = p;
      checks++;
      if (obs_tmo || obs_ack !== (p ? 2'b10 : 2'b01) || obs_post !== 3'b000) begin
        errors++; $display("FAIL rand_ack_%0d got ack=%b post=%b tmo=%0d want port %0d", n, obs_ack, obs_post, obs_tmo, p);
      end
      checks++;
      if (obs_cmd !== {!pwe, pwe} || obs_addr !== paddr || (pwe && obs_wdata !== pwd) || !obs_stable) begin
        errors++; $display("FAIL rand_cmd_%0d got cmd=%b addr=%h wdata=%h stable=%0d want %b %h %h", n, obs_cmd, obs_addr, obs_wdata, obs_stable, {!pwe, pwe}, paddr, pwd);
      end
      checks++;
      if (obs_cyc !== ecyc || obs_err !== terr || obs_rdata !== erd) begin
        errors++; $display("FAIL rand_resp_%0d got len=%0d err=%b rdata=%h want %0d %b %h", n, obs_cyc, obs_err, obs_rdata, ecyc, terr, erd);
      end
    end
  endtask

  initial begin
    reset = 0; mlast = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; c_rdata = '0; c_done = 0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1;
    test_single_read();
    test_write();
    test_contention();
    test_watchdog();
    test_collision();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
